// File: rtl/writeback_regfile.sv
// Writeback stage plus 32x32 register file.
// Selects the writeback value from the MEM/WB latch and commits it to the
// register file. Serves two combinational read ports with same-cycle write
// bypass. Streams the whole register file, LSB byte first, to the debug unit
// over a valid/ready handshake.
module writeback_regfile #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int N_REGS  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NB_DATA-1:0] i_output_mem,
    input  logic [NB_DATA-1:0] i_ALU_res,
    input  logic [NB_ADDR-1:0] i_addr_reg_dst,
    input  logic [NB_DATA-1:0] i_pc_to_reg,
    input  logic               is_RegWrite,
    input  logic               is_MemtoReg,
    input  logic               is_write_pc,
    input  logic [NB_ADDR-1:0] i_addr_rs,
    input  logic [NB_ADDR-1:0] i_addr_rt,
    output logic [NB_DATA-1:0] o_data_rs,
    output logic [NB_DATA-1:0] o_data_rt,
    output logic [NB_DATA-1:0] o_wb_data,
    input  logic               i_dump_start,
    output logic [7:0]         o_dump_data,
    output logic               o_dump_valid,
    input  logic               i_dump_ready,
    output logic               o_dump_busy,
    output logic               o_dump_done
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    localparam int                NB_IDX   = $clog2(N_REGS);
    localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_REGS - 1);

    state_t             state, state_next;
    logic [NB_DATA-1:0] regs [N_REGS];
    logic [NB_DATA-1:0] wb_data;
    logic               wb_en;
    logic [NB_DATA-1:0] shift;
    logic [NB_IDX-1:0]  idx;
    logic [1:0]         byte_cnt;
    logic [NB_ADDR-1:0] dump_addr;
    logic [NB_DATA-1:0] dump_val;

    // Link value beats memory data, which beats the ALU result.
    assign wb_data   = is_write_pc ? i_pc_to_reg : (is_MemtoReg ? i_output_mem : i_ALU_res);
    assign o_wb_data = wb_data;
    // r0 is hardwired to zero, so a write aimed at it is simply not enabled.
    assign wb_en     = is_RegWrite && (i_addr_reg_dst != '0);

    // Read ports see the value being written this cycle (bypass).
    assign o_data_rs = (i_addr_rs == '0) ? '0 :
                       (wb_en && (i_addr_rs == i_addr_reg_dst)) ? wb_data : regs[i_addr_rs];
    assign o_data_rt = (i_addr_rt == '0) ? '0 :
                       (wb_en && (i_addr_rt == i_addr_reg_dst)) ? wb_data : regs[i_addr_rt];

    // The dump captures with the same bypass rule as the read ports.
    assign dump_addr = NB_ADDR'(idx);
    assign dump_val  = (dump_addr == '0) ? '0 :
                       (wb_en && (dump_addr == i_addr_reg_dst)) ? wb_data : regs[dump_addr];

    assign o_dump_busy = (state != IDLE);

    // Register file: cleared on reset, one write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[i_addr_reg_dst] <= wb_data;
        end
    end

    // Dump FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Dump FSM next state and handshake outputs.
    always_comb begin
        state_next   = state;
        o_dump_valid = 1'b0;
        o_dump_data  = '0;
        o_dump_done  = 1'b0;
        case (state)
            IDLE: if (i_dump_start) state_next = LOAD;
            LOAD: state_next = SEND;
            SEND: begin
                o_dump_valid = 1'b1;
                o_dump_data  = shift[7:0];
                if (i_dump_ready && (byte_cnt == 2'd3))
                    state_next = (idx == LAST_IDX) ? DONE : LOAD;
            end
            DONE: begin
                o_dump_done = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Dump datapath: register index, byte counter and byte shifter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx      <= '0;
            byte_cnt <= '0;
            shift    <= '0;
        end else begin
            case (state)
                IDLE: if (i_dump_start) idx <= '0;
                LOAD: begin
                    shift    <= dump_val;
                    byte_cnt <= '0;
                end
                SEND: if (i_dump_ready) begin
                    shift    <= shift >> 8;
                    byte_cnt <= byte_cnt + 2'd1;
                    if ((byte_cnt == 2'd3) && (idx != LAST_IDX)) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Testbench for writeback_regfile: a register-array / byte-queue model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_output_mem, i_ALU_res, i_pc_to_reg;
    logic [4:0]  i_addr_reg_dst, i_addr_rs, i_addr_rt;
    logic        is_RegWrite, is_MemtoReg, is_write_pc;
    logic [31:0] o_data_rs, o_data_rt, o_wb_data;
    logic        i_dump_start, i_dump_ready;
    logic [7:0]  o_dump_data;
    logic        o_dump_valid, o_dump_busy, o_dump_done;

    always #5 clk = ~clk;

    writeback_regfile dut (
        .clk(clk), .rst(rst),
        .i_output_mem(i_output_mem), .i_ALU_res(i_ALU_res),
        .i_addr_reg_dst(i_addr_reg_dst), .i_pc_to_reg(i_pc_to_reg),
        .is_RegWrite(is_RegWrite), .is_MemtoReg(is_MemtoReg), .is_write_pc(is_write_pc),
        .i_addr_rs(i_addr_rs), .i_addr_rt(i_addr_rt),
        .o_data_rs(o_data_rs), .o_data_rt(o_data_rt), .o_wb_data(o_wb_data),
        .i_dump_start(i_dump_start), .o_dump_data(o_dump_data),
        .o_dump_valid(o_dump_valid), .i_dump_ready(i_dump_ready),
        .o_dump_busy(o_dump_busy), .o_dump_done(o_dump_done)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- model ----------------
    logic [31:0] mregs [32];
    logic [7:0]  q[$];
    logic        mbusy     = 1'b0;
    logic        done_due  = 1'b0;
    logic        done_seen = 1'b0;
    logic        chk_en    = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data;
    logic [7:0]  exp_b;
    logic [7:0]  logb[$];

    function automatic logic [31:0] m_wb();
        if (is_write_pc) return i_pc_to_reg;
        if (is_MemtoReg) return i_output_mem;
        return i_ALU_res;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (is_RegWrite && (i_addr_reg_dst != 5'd0) && (a == i_addr_reg_dst)) return m_wb();
        return mregs[a];
    endfunction

    // Model state update at each edge; a started dump queues all 128 bytes.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
            q.delete();
            mbusy = 1'b0; done_due = 1'b0; done_seen = 1'b0; prev_stall = 1'b0;
        end else begin
            if (is_RegWrite && (i_addr_reg_dst != 5'd0)) mregs[i_addr_reg_dst] = m_wb();
            if (done_seen) begin
                mbusy = 1'b0; done_seen = 1'b0;
            end else if (!mbusy && i_dump_start) begin
                mbusy = 1'b1;
                for (int r = 0; r < 32; r++)
                    for (int b = 0; b < 4; b++) q.push_back(mregs[r][8*b +: 8]);
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) if (chk_en) begin
        chk("wb_data", o_wb_data, m_wb());
        chk("data_rs", o_data_rs, m_read(i_addr_rs));
        chk("data_rt", o_data_rt, m_read(i_addr_rt));
        chk("dump_busy", {31'h0, o_dump_busy}, {31'h0, mbusy});
        chk("dump_done", {31'h0, o_dump_done}, {31'h0, done_due});
        if (done_due) begin done_seen = 1'b1; done_due = 1'b0; end
        if (!mbusy) chk("valid_when_idle", {31'h0, o_dump_valid}, 32'h0);
        if (prev_stall) begin
            chk("hold_valid", {31'h0, o_dump_valid}, 32'h1);
            chk("hold_data", {24'h0, o_dump_data}, {24'h0, prev_data});
        end
        prev_stall = o_dump_valid && !i_dump_ready;
        prev_data  = o_dump_data;
        if (o_dump_valid && i_dump_ready) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL dump_extra_byte: got byte %h expected no byte", o_dump_data);
            end else begin
                exp_b = q.pop_front();
                chk("dump_byte", {24'h0, o_dump_data}, {24'h0, exp_b});
                if (q.size() == 0) done_due = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] dst, input logic [31:0] alu,
                          input logic [31:0] mem, input logic [31:0] pc,
                          input logic m2r, input logic wpc);
        is_RegWrite = we; i_addr_reg_dst = dst; i_ALU_res = alu;
        i_output_mem = mem; i_pc_to_reg = pc; is_MemtoReg = m2r; is_write_pc = wpc;
    endtask

    // Runs one dump; bp selects the 1,0,0,1 ready pattern plus a stray start.
    task automatic run_dump(input bit bp, output int done_cyc, output int nbytes);
        bit seen;
        logb.delete(); done_cyc = -1; nbytes = 0; seen = 1'b0;
        i_dump_start = 1'b1; i_dump_ready = 1'b1;
        step();
        i_dump_start = 1'b0;
        for (int cyc = 1; cyc < 1000 && !seen; cyc++) begin
            i_dump_ready = bp ? ((cyc % 4 == 1) || (cyc % 4 == 0)) : 1'b1;
            i_dump_start = bp && (cyc == 50);
            @(negedge clk);
            if (o_dump_valid && i_dump_ready) begin logb.push_back(o_dump_data); nbytes++; end
            if (o_dump_done) begin seen = 1'b1; done_cyc = cyc; end
            step();
        end
        i_dump_start = 1'b0; i_dump_ready = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, nb, nd, n;
        rst = 1'b0;
        set_wb(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        i_addr_rs = 5'd0; i_addr_rt = 5'd0;
        i_dump_start = 1'b0; i_dump_ready = 1'b1;
        step(); step();
        rst = 1'b1;
        chk_en = 1'b1;
        i_addr_rs = 5'd5; i_addr_rt = 5'd31;
        #2;
        chk("reset_rs", o_data_rs, 32'h0);
        chk("reset_rt", o_data_rt, 32'h0);
        chk("reset_valid", {31'h0, o_dump_valid}, 32'h0);
        chk("reset_dump_data", {24'h0, o_dump_data}, 32'h0);

        // Writeback mux: ALU, memory, link.
        step();
        set_wb(1'b1, 5'd5, 32'h11, 32'h22, 32'h33, 1'b0, 1'b0);
        step(); is_RegWrite = 1'b0; #2;
        chk("mux_alu", o_data_rs, 32'h11);
        set_wb(1'b1, 5'd5, 32'h11, 32'h22, 32'h33, 1'b1, 1'b0);
        step(); is_RegWrite = 1'b0; #2;
        chk("mux_mem", o_data_rs, 32'h22);
        set_wb(1'b1, 5'd5, 32'h11, 32'h22, 32'h33, 1'b1, 1'b1);
        #2;
        chk("mux_pc_wb", o_wb_data, 32'h33);
        step(); is_RegWrite = 1'b0; #2;
        chk("mux_pc", o_data_rs, 32'h33);

        // r0 protection.
        i_addr_rs = 5'd0;
        set_wb(1'b1, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("r0_bypass", o_data_rs, 32'h0);
        chk("r0_wb_data", o_wb_data, 32'hDEADBEEF);
        step(); is_RegWrite = 1'b0; #2;
        chk("r0_after", o_data_rs, 32'h0);

        // Bypass.
        set_wb(1'b1, 5'd7, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        set_wb(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        i_addr_rs = 5'd7; i_addr_rt = 5'd7; #2;
        chk("bypass_before", o_data_rs, 32'h1);
        step();
        set_wb(1'b1, 5'd7, 32'hCAFE, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("bypass_rs", o_data_rs, 32'hCAFE);
        chk("bypass_rt", o_data_rt, 32'hCAFE);
        step();
        set_wb(1'b0, 5'd7, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("array_rs", o_data_rs, 32'hCAFE);
        chk("array_rt", o_data_rt, 32'hCAFE);

        // Load regs[i] = 0x01010101*i.
        for (int i = 1; i < 32; i++) begin
            step();
            set_wb(1'b1, 5'(i), 32'h01010101 * i, 32'h0, 32'h0, 1'b0, 1'b0);
        end
        step();
        set_wb(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        i_addr_rs = 5'd31; i_addr_rt = 5'd16; #2;
        chk("fill_r31", o_data_rs, 32'h1F1F1F1F);
        chk("fill_r16", o_data_rt, 32'h10101010);

        // Full dump with ready tied high.
        step();
        run_dump(1'b0, dc, nb);
        chk("full_done_cycle", dc, 161);
        chk("full_nbytes", nb, 128);
        if (nb == 128) begin
            chk("full_byte3", {24'h0, logb[3]}, 32'h00);
            chk("full_byte4", {24'h0, logb[4]}, 32'h01);
            chk("full_byte127", {24'h0, logb[127]}, 32'h1F);
        end

        // Backpressure plus ignored mid-dump start.
        step();
        run_dump(1'b1, dc, nb);
        chk("bp_nbytes", nb, 128);
        chk("bp_done_seen", {31'h0, dc > 161}, 32'h1);
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_dump_done || o_dump_busy) nd++;
            step();
        end
        chk("bp_no_restart", nd, 0);

        // Reset mid-dump after 10 bytes.
        i_dump_start = 1'b1; i_dump_ready = 1'b1;
        step();
        i_dump_start = 1'b0;
        n = 0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(negedge clk);
            if (o_dump_valid && i_dump_ready) n++;
            if (n < 10) step();
        end
        chk("abort_reached_10", n, 10);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        i_addr_rs = 5'd5; i_addr_rt = 5'd31; #2;
        chk("abort_valid", {31'h0, o_dump_valid}, 32'h0);
        chk("abort_busy", {31'h0, o_dump_busy}, 32'h0);
        chk("abort_rs", o_data_rs, 32'h0);
        chk("abort_rt", o_data_rt, 32'h0);
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_dump_done) nd++;
            step();
        end
        chk("abort_no_done", nd, 0);

        run_dump(1'b0, dc, nb);
        chk("zero_done_cycle", dc, 161);
        chk("zero_nbytes", nb, 128);
        if (nb == 128) chk("zero_byte124", {24'h0, logb[124]}, 32'h0);

        step(); step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
